fetch_decode_queue: RTL and testbench

Elastic buffer between the instruction fetch stage and the instruction decode stage of the VeSPA CPU pipeline. It captures {PC, instruction} pairs produced by fetch into a small first-word-fall-through queue. It presents them to decode with a valid/ready handshake, back-pressures fetch through its stall input, and discards all buffered instructions on a pipeline flush (branch/jump/interrupt redirect).

---
 rtl/fetch_decode_queue.sv | 94 +++++++++
 tb/tb_fetch_decode_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Elastic first-word-fall-through queue between fetch and decode.
// Holds {PC, instruction} pairs; back-pressures fetch when full and drops everything on flush.
module fetch_decode_queue #(
  parameter int DEPTH        = 2,
  parameter int BUS_W        = 32,
  parameter int DROP_BUBBLES = 1
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Flush,
  input  logic                         i_Valid,
  input  logic [BUS_W-1:0]             i_Instr,
  input  logic [BUS_W-1:0]             i_Pc,
  output logic                         o_Stall,
  output logic                         o_Valid,
  output logic [BUS_W-1:0]             o_Instr,
  output logic [BUS_W-1:0]             o_Pc,
  input  logic                         i_Ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BUS_W-1:0] instrMem [DEPTH];
  logic [BUS_W-1:0] pcMem    [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic isBubble;
  logic push;
  logic pop;

  // Handshake qualification; the stall path depends only on registered count.
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == {CNT_W{1'b0}});
    isBubble = (DROP_BUBBLES != 0) && (i_Instr == {BUS_W{1'b0}});
    push     = i_Valid && !full && !i_Flush && !isBubble;
    pop      = !empty && i_Ready && !i_Flush;
  end

  // Storage write; contents are don't-care after reset so no reset here.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      instrMem[wrPtr] <= i_Instr;
      pcMem[wrPtr]    <= i_Pc;
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Flush) begin
      wrPtr <= {PTR_W{1'b0}};
      rdPtr <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end else begin
        wrPtr <= wrPtr;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end else begin
        rdPtr <= rdPtr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation: zeros when empty so decode never sees stale data.
  always_comb begin
    o_Stall = full;
    o_Valid = !empty;
    o_Count = count;
    if (empty) begin
      o_Instr = {BUS_W{1'b0}};
      o_Pc    = {BUS_W{1'b0}};
    end else begin
      o_Instr = instrMem[rdPtr];
      o_Pc    = pcMem[rdPtr];
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: directed scenarios plus a randomised soak.
// Two instances share inputs; sel chooses the bubble-dropping (0) or bubble-keeping (1) one.
module tb_fetch_decode_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        vIn = 1'b0;
  logic [31:0] instrIn = 32'd0;
  logic [31:0] pcIn = 32'd0;
  logic        ready = 1'b0;

  logic        stall1, valid1, stall0, valid0;
  logic [31:0] instr1, pc1, instr0, pc0;
  logic [1:0]  count1, count0;

  logic        sel = 1'b0;
  logic        monOn = 1'b0;
  logic [63:0] expQ[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(DEPTH), .BUS_W(32), .DROP_BUBBLES(1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Valid(vIn), .i_Instr(instrIn),
    .i_Pc(pcIn), .o_Stall(stall1), .o_Valid(valid1), .o_Instr(instr1), .o_Pc(pc1),
    .i_Ready(ready), .o_Count(count1));

  fetch_decode_queue #(.DEPTH(DEPTH), .BUS_W(32), .DROP_BUBBLES(0)) dutKeep (
    .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Valid(vIn), .i_Instr(instrIn),
    .i_Pc(pcIn), .o_Stall(stall0), .o_Valid(valid0), .o_Instr(instr0), .o_Pc(pc0),
    .i_Ready(ready), .o_Count(count0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare outputs with the scoreboard, then retire the head on a handshake.
  always @(negedge clk) begin
    if (monOn) begin
      logic        mValid, mStall;
      logic [31:0] mInstr, mPc, mCount;
      mValid = sel ? valid0 : valid1;
      mStall = sel ? stall0 : stall1;
      mInstr = sel ? instr0 : instr1;
      mPc    = sel ? pc0 : pc1;
      mCount = sel ? {30'd0, count0} : {30'd0, count1};
      chk("count", mCount, expQ.size());
      chk("valid", {31'd0, mValid}, {31'd0, expQ.size() != 0});
      chk("stall", {31'd0, mStall}, {31'd0, expQ.size() == DEPTH});
      if (expQ.size() != 0) begin
        chk("head_pc", mPc, expQ[0][63:32]);
        chk("head_instr", mInstr, expQ[0][31:0]);
      end else begin
        chk("empty_pc", mPc, 32'd0);
        chk("empty_instr", mInstr, 32'd0);
      end
      if (rst || flush) begin
        expQ.delete();
      end else if (mValid && ready && expQ.size() != 0) begin
        void'(expQ.pop_front());
      end
    end
  end

  // One clock of stimulus; exp says whether this input must be captured (auto: derive from scoreboard).
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl, input logic exp, input logic auto);
    logic accept;
    @(posedge clk);
    #1;
    vIn = v; instrIn = ins; pcIn = pc; ready = rdy; flush = fl;
    accept = auto ? (v && !fl && (sel || ins != 32'd0) && expQ.size() < DEPTH) : exp;
    @(negedge clk);
    #1;
    if (accept) expQ.push_back({pc, ins});
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1; vIn = 1'b0; ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset held two cycles, then idle.
    @(posedge clk);
    #1;
    monOn = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 2: streaming with decode always ready.
    cyc(1'b1, 32'h11, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h22, 32'd4,  1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h33, 32'd8,  1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h44, 32'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 3: back-pressure; PC 8 rejected while full, even on the first popping cycle.
    cyc(1'b1, 32'h11, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h22, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h33, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 32'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 4: flush with two entries held; the PC 0x40 input is dropped.
    cyc(1'b1, 32'h55, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h66, 32'h24, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h77, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0,  32'd0,  1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0,  32'd0,  1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 5a: bubble dropped.
    cyc(1'b1, 32'h11, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h00, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 32'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 6: random traffic with wrap-around, simultaneous push/pop and rare flushes.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ins;
      ins = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      cyc($urandom_range(0, 9) < 7, ins, 32'(i * 4), $urandom_range(0, 1) == 1,
          $urandom_range(0, 49) == 0, 1'b0, 1'b1);
    end
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 5b: bubble-keeping instance sees all three.
    doReset();
    sel = 1'b1;
    cyc(1'b1, 32'h11, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h00, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h22, 32'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
          32'(i * 4), $urandom_range(0, 1) == 1, 1'b0, 1'b0, 1'b1);
    end
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
